// File: rtl/db_pkg.sv
// Shared types and constants for the button-bounce emulator.
// Holds the FSM state encoding, LFSR polynomial and counter width.
package db_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int          CNT_W        = 8;

    // One Galois step: shift right, fold the mask in on a shifted-out 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/db_lfsr16.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1).
// A zero seed would lock the register, so it is replaced by 1.
module db_lfsr16
    import db_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] seed_safe;

    assign seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;

    // Advance one step per cycle; reload the seed on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= seed_safe;
        end else begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/db_bounce_gen.sv
// Button-bounce emulator: turns a clean level change into a
// pseudo-random glitch burst followed by a stable settle window.
module db_bounce_gen
    import db_pkg::*;
#(
    parameter int unsigned BOUNCE_CYCLES = 8,
    parameter int unsigned SETTLE_CYCLES = 6,
    parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic level_in,
    output logic button_out,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] BOUNCE_LD = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             target;
    logic             target_n;
    logic             cur_level;
    logic             cur_n;
    logic             btn_n;
    logic             busy_n;
    logic             done_n;
    logic [15:0]      lfsr_q;
    logic             glitch;
    logic             lfsr_unused;

    db_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Only the low bit drives the glitch pattern.
    assign glitch      = lfsr_q[0];
    assign lfsr_unused = ^lfsr_q[15:1];

    // State, counter and registered outputs; reset aborts any burst.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            target     <= 1'b0;
            cur_level  <= 1'b0;
            button_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            target     <= target_n;
            cur_level  <= cur_n;
            button_out <= btn_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // Next-state and next-output logic for the bounce sequence.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        target_n = target;
        cur_n    = cur_level;
        btn_n    = button_out;
        busy_n   = busy;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!en) begin
                    cur_n = level_in;
                    btn_n = level_in;
                end else if (level_in != cur_level) begin
                    // First burst cycle shows the target to force an edge.
                    target_n = level_in;
                    btn_n    = level_in;
                    cnt_n    = BOUNCE_LD;
                    state_n  = BOUNCE;
                    busy_n   = 1'b1;
                end
            end
            BOUNCE: begin
                if (cnt == '0) begin
                    btn_n   = target;
                    cnt_n   = SETTLE_LD;
                    state_n = SETTLE;
                end else begin
                    btn_n = glitch;
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            SETTLE: begin
                btn_n = target;
                if (cnt == '0) begin
                    cur_n   = target;
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/db_bounce_gen.md
Name: db_bounce_gen

Overview:
Synthesizable button-bounce emulator, the transmitting end of the debounce path. It converts a clean requested level into a contact-bounce waveform: a pseudo-random glitch burst followed by a guaranteed stable hold. Its output drives the debouncer's button input for on-chip self-test and for closed-loop benches.

Parameters:
BOUNCE_CYCLES, 8, length of the glitch burst in clk cycles; legal values 1..255.
SETTLE_CYCLES, 6, cycles the final level is held stable before done; legal values 1..255. Must be at least debouncer LIMIT+2 for a clean handoff.
LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
en  input  1  1 = emulate bounce; 0 = bypass (output follows level_in)
level_in  input  1  clean requested button level
button_out  output  1  emulated button line (registered)
busy  output  1  high while in BOUNCE or SETTLE
done  output  1  one-cycle pulse when a transition has fully settled

Behaviour:
- Reset: rst_n low at a posedge forces state=IDLE, cur_level=0, button_out=0, busy=0, done=0, counter=0, lfsr=seed. Reset applies in any state and aborts a burst immediately; there is no recovery of the old target.
- LFSR: 16-bit Galois, mask 16'hB400 (x^16+x^14+x^13+x^11+1). Shift right, XOR the mask when the shifted-out bit is 1. Free-runs every cycle after reset.
- State IDLE:
  - en=0: cur_level<=level_in and button_out<=level_in (1-cycle latency). No busy, no done.
  - en=1 and level_in!=cur_level: latch target<=level_in, button_out<=level_in, counter<=BOUNCE_CYCLES-1, go to BOUNCE, busy<=1.
  - en=1 and level_in==cur_level: hold.
- State BOUNCE:
  - button_out<=lfsr[0] each cycle.
  - When counter==0: button_out<=target, counter<=SETTLE_CYCLES-1, go to SETTLE. Otherwise decrement the counter.
  - The first burst cycle always shows target, so at least one edge is emitted.
- State SETTLE:
  - button_out held at target.
  - When counter==0: cur_level<=target, go to IDLE, busy<=0, done<=1. Otherwise decrement.
- done is high for exactly the first IDLE cycle after settle; it defaults to 0 otherwise.
- Timing: level change sampled at edge N (IDLE, en=1). Then:
  - Burst occupies button_out for cycles N+1..N+BOUNCE_CYCLES.
  - Stable target holds for the next SETTLE_CYCLES cycles.
  - done at cycle N+BOUNCE_CYCLES+SETTLE_CYCLES+1.
- level_in and en are ignored outside IDLE. A toggle mid-burst is only seen when back in IDLE. If level_in then differs from cur_level, a new burst starts in the same cycle done is asserted.
- A glitch shorter than one cycle is not representable; every level is held for at least one clk.
- The counter is 8 bits wide, with no wrap: BOUNCE_CYCLES=1 and SETTLE_CYCLES=1 give single-cycle phases.

Decomposition:
- Shared package db_pkg:
  - state enum {IDLE, BOUNCE, SETTLE} (2 bits)
  - LFSR_MASK = 16'hB400
  - DEFAULT_SEED = 16'hACE1
  - counter width constant = 8
- Sub-module db_lfsr16 (clk, rst_n, seed, q[15:0]): the free-running Galois LFSR with synchronous reset to the seed and zero-seed substitution.
- The FSM, counter and output register live in db_bounce_gen.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles with level_in=1 -> button_out=0, busy=0, done=0. After release with en=1, a burst starts on the next edge.
- Rising transition (8/6 defaults): level_in 0->1 at cycle N -> button_out=1 at N+1; bits N+2..N+8 equal the LFSR[0] reference model from 16'hACE1; button_out=1 for N+9..N+14; busy high for N+1..N+14; done=1 only at N+15.
- Bypass: en=0, toggle level_in each cycle -> button_out equals level_in delayed 1 cycle, and busy and done stay 0.
- Mid-burst input change: level_in 0->1, then back to 0 at N+4 -> the burst completes to 1 with done at N+15. A second burst toward 0 starts at edge N+15, giving button_out=0 at N+16.
- Reset mid-burst: rst_n=0 at N+5 -> at the next edge button_out=0, busy=0, and no done pulse.
- Closed loop with the team's debouncer (LIMIT=4) driven by button_out: over 20 random level changes, the debouncer output changes exactly once per done, always to target, and never during BOUNCE.
